// File: rtl/retospect_lif_neuron_if.sv
// Signal bundle between the neurochip array fabric and one LIF neuron tile:
// config chain, network clear, clockbox decay strobes, dendrites and observation outputs.
interface retospect_lif_neuron_if #(
  parameter int N_DEND   = 4,
  parameter int POT_BITS = 6,
  parameter int N_DECAY  = 8
);
  logic                config_en;
  logic                bs_in;
  logic                bs_out;
  logic                nn_clear;
  logic [N_DECAY-1:0]  decay_bus;
  logic [N_DEND-1:0]   dendrite;
  logic                axon;
  logic [POT_BITS-1:0] potential;
  logic                refractory;

  modport master (
    output config_en, bs_in, nn_clear, decay_bus, dendrite,
    input  bs_out, axon, potential, refractory
  );

  modport slave (
    input  config_en, bs_in, nn_clear, decay_bus, dendrite,
    output bs_out, axon, potential, refractory
  );
endinterface

// File: rtl/retospect_lif_neuron.sv
// Parametrised leaky integrate-and-fire neuron: serial config chain, signed weights,
// programmable threshold, selectable leak, refractory period and a one-cycle registered spike.
module retospect_lif_neuron #(
  parameter int N_DEND    = 4,
  parameter int W_BITS    = 4,
  parameter int POT_BITS  = 6,
  parameter int REFR_BITS = 3,
  parameter int N_DECAY   = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  retospect_lif_neuron_if.slave  nif
);
  localparam int SEL_BITS = $clog2(N_DECAY);
  localparam int CFG_LEN  = N_DEND*W_BITS + POT_BITS + SEL_BITS + REFR_BITS + 1;
  localparam int SUM_W    = POT_BITS + W_BITS + $clog2(N_DEND) + 1;
  localparam int NXT_W    = SUM_W + 1;
  localparam int THR_LSB  = N_DEND*W_BITS;
  localparam int SEL_LSB  = THR_LSB + POT_BITS;
  localparam int REFR_LSB = SEL_LSB + SEL_BITS;
  localparam int LEAK_BIT = CFG_LEN - 1;
  localparam logic signed [NXT_W-1:0] POT_MAX_W = NXT_W'((1 << POT_BITS) - 1);

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CFG_LEN-1:0]     cfg_q, cfg_d;
  logic [POT_BITS-1:0]    pot_q, pot_d;
  logic [REFR_BITS-1:0]   refr_cnt_q, refr_cnt_d;
  logic                   axon_q, axon_d;

  logic [POT_BITS-1:0]    thresh_s;
  logic [SEL_BITS-1:0]    decay_sel_s;
  logic [REFR_BITS-1:0]   refr_s;
  logic                   leak_mode_s;
  logic                   decay_hit_s;
  logic [POT_BITS-1:0]    decayed_s;
  logic [N_DEND-1:0][SUM_W-1:0] term_s;
  logic signed [SUM_W-1:0] sum_s;
  logic signed [NXT_W-1:0] next_wide_s;
  logic [POT_BITS-1:0]    next_pot_s;
  logic                   fire_s;

  assign thresh_s    = cfg_q[THR_LSB +: POT_BITS];
  assign decay_sel_s = cfg_q[SEL_LSB +: SEL_BITS];
  assign refr_s      = cfg_q[REFR_LSB +: REFR_BITS];
  assign leak_mode_s = cfg_q[LEAK_BIT];
  assign decay_hit_s = nif.decay_bus[decay_sel_s];

  // Each active dendrite contributes its sign-extended weight; inactive ones contribute zero.
  for (genvar gi = 0; gi < N_DEND; gi++) begin : g_dend
    logic [W_BITS-1:0] w_s;
    assign w_s        = cfg_q[gi*W_BITS +: W_BITS];
    assign term_s[gi] = nif.dendrite[gi] ? {{(SUM_W-W_BITS){w_s[W_BITS-1]}}, w_s}
                                         : {SUM_W{1'b0}};
  end

  // Adder tree over the dendrite terms, wide enough that no partial sum overflows.
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    for (int i = 0; i < N_DEND; i++) begin
      sum_s = sum_s + $signed(term_s[i]);
    end
  end

  // Leak, integrate and clamp to the unsigned potential range.
  always_comb begin
    decayed_s = pot_q;
    if (!decay_hit_s) begin
      decayed_s = pot_q;
    end else if (leak_mode_s) begin
      decayed_s = (pot_q == {POT_BITS{1'b0}}) ? {POT_BITS{1'b0}} : pot_q - POT_BITS'(1);
    end else begin
      decayed_s = pot_q >> 1;
    end
    next_wide_s = $signed({{(NXT_W-POT_BITS){1'b0}}, decayed_s}) + {sum_s[SUM_W-1], sum_s};
    if (next_wide_s[NXT_W-1]) begin
      next_pot_s = {POT_BITS{1'b0}};
    end else if (next_wide_s > POT_MAX_W) begin
      next_pot_s = {POT_BITS{1'b1}};
    end else begin
      next_pot_s = next_wide_s[POT_BITS-1:0];
    end
    fire_s = (thresh_s != {POT_BITS{1'b0}}) && (next_pot_s >= thresh_s);
  end

  // Next-state logic: clear beats config shift, config shift freezes the neuron.
  always_comb begin
    cfg_d      = cfg_q;
    pot_d      = pot_q;
    refr_cnt_d = refr_cnt_q;
    state_d    = state_q;
    axon_d     = 1'b0;
    if (nif.nn_clear) begin
      pot_d      = {POT_BITS{1'b0}};
      refr_cnt_d = {REFR_BITS{1'b0}};
      state_d    = ST_INTEGRATE;
    end else if (nif.config_en) begin
      cfg_d = {nif.bs_in, cfg_q[CFG_LEN-1:1]};
    end else begin
      case (state_q)
        ST_INTEGRATE: begin
          if (fire_s) begin
            pot_d  = {POT_BITS{1'b0}};
            axon_d = 1'b1;
            if (refr_s != {REFR_BITS{1'b0}}) begin
              refr_cnt_d = refr_s;
              state_d    = ST_REFRACT;
            end else begin
              state_d = ST_INTEGRATE;
            end
          end else begin
            pot_d = next_pot_s;
          end
        end
        ST_REFRACT: begin
          pot_d = {POT_BITS{1'b0}};
          if (refr_cnt_q <= REFR_BITS'(1)) begin
            refr_cnt_d = {REFR_BITS{1'b0}};
            state_d    = ST_INTEGRATE;
          end else begin
            refr_cnt_d = refr_cnt_q - REFR_BITS'(1);
          end
        end
        default: begin
          pot_d      = {POT_BITS{1'b0}};
          refr_cnt_d = {REFR_BITS{1'b0}};
          state_d    = ST_INTEGRATE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INTEGRATE;
      cfg_q      <= {CFG_LEN{1'b0}};
      pot_q      <= {POT_BITS{1'b0}};
      refr_cnt_q <= {REFR_BITS{1'b0}};
      axon_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      pot_q      <= pot_d;
      refr_cnt_q <= refr_cnt_d;
      axon_q     <= axon_d;
    end
  end

  assign nif.bs_out     = cfg_q[0];
  assign nif.axon       = axon_q;
  assign nif.potential  = pot_q;
  assign nif.refractory = (state_q == ST_REFRACT);
endmodule

// File: tb/tb_retospect_lif_neuron.sv
// Directed bench for retospect_lif_neuron with default parameters (29-bit config chain);
// every expected value below is hand-computed from the neuron's behaviour.
module tb_retospect_lif_neuron;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  retospect_lif_neuron_if nif ();
  retospect_lif_neuron dut (.clk(clk), .rst_n(rst_n), .nif(nif));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] mk_cfg(input logic [3:0] w0, input logic [3:0] w1,
                                         input logic [3:0] w2, input logic [3:0] w3,
                                         input logic [5:0] thr, input logic [2:0] dsel,
                                         input logic [2:0] refr, input logic leak);
    return {leak, refr, dsel, thr, w3, w2, w1, w0};
  endfunction

  task automatic shift_cfg(input logic [28:0] v);
    for (int i = 0; i < 29; i++) begin
      nif.bs_in     = v[i];
      nif.config_en = 1'b1;
      step();
    end
    nif.config_en = 1'b0;
    nif.bs_in     = 1'b0;
  endtask

  // Shift the chain out LSB first and compare bs_out against an expected config word.
  task automatic verify_cfg(input string tag, input logic [28:0] v);
    check_eq(tag, 32'(nif.bs_out), 32'(v[0]));
    for (int j = 1; j < 29; j++) begin
      nif.bs_in     = 1'b0;
      nif.config_en = 1'b1;
      step();
      check_eq(tag, 32'(nif.bs_out), 32'(v[j]));
    end
    nif.config_en = 1'b0;
  endtask

  task automatic clear_pot();
    nif.nn_clear = 1'b1;
    step();
    nif.nn_clear = 1'b0;
  endtask

  logic [28:0] pat_a;
  logic [28:0] pat_b;
  logic [28:0] cfg5;
  logic [28:0] pump;

  initial begin
    pat_a = 29'h0A5C3E91;
    pat_b = ~pat_a;
    rst_n = 1'b0;
    nif.config_en = 1'b0;
    nif.bs_in     = 1'b0;
    nif.nn_clear  = 1'b0;
    nif.decay_bus = 8'b0000_0010;
    nif.dendrite  = 4'b0000;
    step();
    step();
    check_eq("rst_axon", 32'(nif.axon), 32'd0);
    check_eq("rst_pot", 32'(nif.potential), 32'd0);
    check_eq("rst_refr", 32'(nif.refractory), 32'd0);
    check_eq("rst_bsout", 32'(nif.bs_out), 32'd0);
    rst_n = 1'b1;

    // 1: chain latency, dendrites ignored while shifting
    nif.dendrite = 4'b1111;
    for (int i = 0; i < 29; i++) begin
      nif.bs_in = pat_a[i];
      nif.config_en = 1'b1;
      step();
      check_eq("t1_pot", 32'(nif.potential), 32'd0);
      check_eq("t1_axon", 32'(nif.axon), 32'd0);
    end
    check_eq("t1_chain0", 32'(nif.bs_out), 32'(pat_a[0]));
    for (int j = 1; j < 29; j++) begin
      nif.bs_in = pat_b[j-1];
      step();
      check_eq("t1_chain", 32'(nif.bs_out), 32'(pat_a[j]));
      check_eq("t1_pot2", 32'(nif.potential), 32'd0);
      check_eq("t1_axon2", 32'(nif.axon), 32'd0);
    end
    nif.config_en = 1'b0;
    nif.dendrite = 4'b0000;

    // 2: integrate 3 then fire at threshold 6
    shift_cfg(mk_cfg(4'd3, 4'd0, 4'd0, 4'd0, 6'd6, 3'd0, 3'd0, 1'b0));
    nif.dendrite = 4'b0001;
    step();
    check_eq("t2_pot3", 32'(nif.potential), 32'd3);
    check_eq("t2_noaxon", 32'(nif.axon), 32'd0);
    step();
    check_eq("t2_fire", 32'(nif.axon), 32'd1);
    check_eq("t2_pot0", 32'(nif.potential), 32'd0);
    nif.dendrite = 4'b0000;
    step();
    check_eq("t2_axonlow", 32'(nif.axon), 32'd0);
    check_eq("t2_potstay", 32'(nif.potential), 32'd0);

    // 3: inhibitory weights, low clamp, simultaneous summation (w0=-8, w1=7, w2=5)
    shift_cfg(mk_cfg(4'h8, 4'd7, 4'd5, 4'd0, 6'd63, 3'd0, 3'd0, 1'b0));
    nif.dendrite = 4'b0100;
    step();
    check_eq("t3_pot5", 32'(nif.potential), 32'd5);
    nif.dendrite = 4'b0001;
    step();
    check_eq("t3_clamp0", 32'(nif.potential), 32'd0);
    nif.dendrite = 4'b0011;
    step();
    check_eq("t3_sum_m1", 32'(nif.potential), 32'd0);
    nif.dendrite = 4'b0111;
    step();
    check_eq("t3_sum_p4", 32'(nif.potential), 32'd4);
    nif.dendrite = 4'b0000;

    // 4: saturation with thresh=0, then shift and linear leak from 40
    clear_pot();
    pump = mk_cfg(4'd7, 4'd7, 4'd6, 4'd0, 6'd0, 3'd0, 3'd0, 1'b0);
    shift_cfg(pump);
    nif.dendrite = 4'b0111;
    step();
    check_eq("t4_p20", 32'(nif.potential), 32'd20);
    step();
    step();
    check_eq("t4_p60", 32'(nif.potential), 32'd60);
    step();
    check_eq("t4_sat", 32'(nif.potential), 32'd63);
    step();
    check_eq("t4_sat2", 32'(nif.potential), 32'd63);
    check_eq("t4_nofire", 32'(nif.axon), 32'd0);
    nif.dendrite = 4'b0000;
    clear_pot();
    nif.dendrite = 4'b0111;
    step();
    step();
    nif.dendrite = 4'b0000;
    check_eq("t4_p40", 32'(nif.potential), 32'd40);
    shift_cfg(mk_cfg(4'd7, 4'd7, 4'd6, 4'd0, 6'd0, 3'd1, 3'd0, 1'b0));
    check_eq("t4_frozen", 32'(nif.potential), 32'd40);
    step();
    check_eq("t4_shr20", 32'(nif.potential), 32'd20);
    step();
    check_eq("t4_shr10", 32'(nif.potential), 32'd10);
    step();
    check_eq("t4_shr5", 32'(nif.potential), 32'd5);
    clear_pot();
    shift_cfg(pump);
    nif.dendrite = 4'b0111;
    step();
    step();
    nif.dendrite = 4'b0000;
    shift_cfg(mk_cfg(4'd7, 4'd7, 4'd6, 4'd0, 6'd0, 3'd1, 3'd0, 1'b1));
    check_eq("t4_lin40", 32'(nif.potential), 32'd40);
    step();
    check_eq("t4_lin39", 32'(nif.potential), 32'd39);
    step();
    check_eq("t4_lin38", 32'(nif.potential), 32'd38);

    // 5: refractory period of 3 cycles
    clear_pot();
    cfg5 = mk_cfg(4'd2, 4'd0, 4'd0, 4'd0, 6'd2, 3'd0, 3'd3, 1'b0);
    shift_cfg(cfg5);
    nif.dendrite = 4'b0001;
    step();
    check_eq("t5_ax1", 32'(nif.axon), 32'd1);
    check_eq("t5_rf1", 32'(nif.refractory), 32'd1);
    step();
    check_eq("t5_ax2", 32'(nif.axon), 32'd0);
    check_eq("t5_rf2", 32'(nif.refractory), 32'd1);
    step();
    check_eq("t5_ax3", 32'(nif.axon), 32'd0);
    check_eq("t5_rf3", 32'(nif.refractory), 32'd1);
    check_eq("t5_pot3", 32'(nif.potential), 32'd0);
    step();
    check_eq("t5_ax4", 32'(nif.axon), 32'd0);
    check_eq("t5_rf4", 32'(nif.refractory), 32'd0);
    step();
    check_eq("t5_ax5", 32'(nif.axon), 32'd1);
    check_eq("t5_rf5", 32'(nif.refractory), 32'd1);

    // 6: clear during refractory keeps config; reset during config shift wipes it
    step();
    check_eq("t6_inrefr", 32'(nif.refractory), 32'd1);
    nif.nn_clear = 1'b1;
    step();
    nif.nn_clear = 1'b0;
    nif.dendrite = 4'b0000;
    check_eq("t6_clr_refr", 32'(nif.refractory), 32'd0);
    check_eq("t6_clr_pot", 32'(nif.potential), 32'd0);
    check_eq("t6_clr_axon", 32'(nif.axon), 32'd0);
    verify_cfg("t6_cfgkeep", cfg5);
    nif.bs_in = 1'b1;
    nif.config_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    check_eq("t6_rst_bsout", 32'(nif.bs_out), 32'd0);
    check_eq("t6_rst_pot", 32'(nif.potential), 32'd0);
    check_eq("t6_rst_refr", 32'(nif.refractory), 32'd0);
    rst_n = 1'b1;
    nif.config_en = 1'b0;
    nif.bs_in = 1'b0;
    verify_cfg("t6_cfgzero", 29'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/retospect_lif_neuron.md
Name: retospect_lif_neuron

Overview:
Parametrised leaky integrate-and-fire neuron cell, the next-generation tile for the neurochip array. It generalises the 4-input fixed-width cell in several ways: configurable dendrite count and weight/potential widths, signed (inhibitory) weights, and a programmable firing threshold. It also adds a selectable leak mode, a refractory period, and a single-cycle registered spike. Configuration is loaded through the array's serial bitstream chain, and leak timing comes from the shared clockbox decay bus.

Parameters:
N_DEND, 4, number of dendrite inputs (1..8)
W_BITS, 4, weight width, two's complement signed
POT_BITS, 6, membrane potential width, unsigned
REFR_BITS, 3, refractory period field width
N_DECAY, 8, decay bus width (power of 2, >=2); SEL_BITS = clog2(N_DECAY)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
config_en  in  1  shift config chain this cycle
bs_in  in  1  config serial in
bs_out  out  1  config serial out, = cfg[0]
nn_clear  in  1  network clear: zero potential/state, keep config
decay_bus  in  N_DECAY  decay strobes from clockbox (bit0 = never, bit1 = always)
dendrite  in  N_DEND  input spikes, sampled each cycle
axon  out  1  registered output spike
potential  out  POT_BITS  current membrane potential (debug/observe)
refractory  out  1  high while in REFRACT

Behaviour:
- Config register cfg[L-1:0], L = N_DEND*W_BITS + POT_BITS + SEL_BITS + REFR_BITS + 1 (defaults: 29).
  - Field map LSB-first: weight i = cfg[i*W_BITS +: W_BITS]; then thresh (POT_BITS); decay_sel (SEL_BITS); refr (REFR_BITS); leak_mode (1, MSB).
- Priority per cycle: !rst_n > nn_clear > config_en > run.
- rst_n low:
  - cfg = 0, pot = 0, refr_cnt = 0, state = INTEGRATE.
  - axon = 0, potential = 0, refractory = 0, bs_out = 0.
- nn_clear: pot = 0, refr_cnt = 0, state = INTEGRATE, axon = 0; cfg unchanged.
- config_en:
  - cfg <= {bs_in, cfg[L-1:1]}.
  - pot, state and refr_cnt frozen; axon = 0; dendrites ignored.
  - Chain latency is L cycles from bs_in to bs_out.
- States:
  - INTEGRATE:
    - decayed = pot if decay_bus[decay_sel]==0.
    - Otherwise decayed = pot>>1 (leak_mode 0) or max(pot-1, 0) (leak_mode 1).
    - sum = signed sum of weight i over all i with dendrite[i]=1, computed at width POT_BITS+W_BITS+clog2(N_DEND)+1; no intermediate overflow.
    - next = clamp(decayed + sum, 0, 2^POT_BITS-1).
    - Fire if thresh != 0 and next >= thresh. On fire:
      - pot <= 0, axon <= 1.
      - If refr != 0: refr_cnt <= refr, state <= REFRACT. Otherwise stay in INTEGRATE.
    - If no fire: pot <= next, axon <= 0.
    - thresh == 0: neuron never fires but still integrates and saturates.
  - REFRACT:
    - axon <= 0, pot held at 0, dendrites and decay ignored.
    - refr_cnt decrements each cycle; when refr_cnt == 1, state <= INTEGRATE and refr_cnt <= 0.
    - Net effect: refr cycles blind after the fire cycle.
- Timing: axon is high for exactly one cycle, the cycle after the edge on which the crossing inputs were sampled.
- Back-to-back fires are possible only with refr = 0; pot restarts from 0 each time.
- Simultaneous excitatory and inhibitory inputs are summed before the clamp, never applied sequentially.
- potential and refractory reflect the registered state, with no combinational path from dendrite.
- Target 120-400 lines of RTL; sum logic is a generate loop over N_DEND.

Test Plan:
1. Reset, then shift a 29-bit pattern with config_en=1, then shift 29 more bits -> bs_out reproduces the first pattern in order, starting at shift cycle 30; pot stays 0 and axon stays 0 throughout.
2. Config w0=3, thresh=6, decay_sel=0, refr=0; dendrite[0] high for 2 cycles -> potential goes 3, then fires (axon=1 for one cycle), potential returns to 0.
3. Config w0=-8, w1=7, thresh=63; pot=5, then assert dendrite[0] alone -> potential clamps to 0. Then assert dendrite[0]+[1] on pot=0 -> potential stays 0 (sum -1, clamped).
4. Config pot=40, decay_sel=1: leak_mode=0 -> potential goes 20, 10, 5 on successive cycles. leak_mode=1 -> potential goes 40, 39, 38 (no dendrites active in either case).
5. Config refr=3, thresh=2, w0=2; hold dendrite[0] high -> axon pattern 1,0,0,0,1,...; refractory high for exactly 3 cycles.
6. Assert nn_clear during REFRACT -> next cycle refractory=0, potential=0, cfg unchanged (verified by re-shifting). Assert rst_n=0 mid-config -> cfg=0 and bs_out=0 next cycle.
